// File: rtl/ex_muldiv_unit_if.sv
// ID/EX -> M-unit -> EX/MEM bundle for the RV32M multiply/divide unit.
// master = pipeline side (drives the op), slave = ex_muldiv_unit.
interface ex_muldiv_unit_if;
    logic        START;
    logic [2:0]  FUNCT3;
    logic [31:0] OPERAND_A;
    logic [31:0] OPERAND_B;
    logic [4:0]  RD_IN;
    logic        FLUSH;
    logic [31:0] RESULT;
    logic [4:0]  RD_OUT;
    logic        DONE;
    logic        BUSY;

    modport master (
        output START, FUNCT3, OPERAND_A, OPERAND_B, RD_IN, FLUSH,
        input  RESULT, RD_OUT, DONE, BUSY
    );

    modport slave (
        input  START, FUNCT3, OPERAND_A, OPERAND_B, RD_IN, FLUSH,
        output RESULT, RD_OUT, DONE, BUSY
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle 33x33 multiplier.
module ex_muldiv_unit (
    input  logic            CLK,
    input  logic            RESET,
    ex_muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] opnd_q, opnd_d;
    logic [63:0] work_q, work_d;
    logic        neg_q, neg_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  rd_out_q, rd_out_d;

    function automatic logic [31:0] fix32(input logic [31:0] v, input logic n);
        return n ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] fix64(input logic [63:0] v, input logic n);
        return n ? (~v + 64'd1) : v;
    endfunction

    // Decode of the op sitting in the ID/EX register
    logic        in_div, a_sgn, b_sgn, a_neg, b_neg;
    logic [31:0] mag_a, mag_b;
    logic        div_zero, div_ovf;

    assign in_div   = bus.FUNCT3[2];
    assign a_sgn    = in_div ? ~bus.FUNCT3[0] : (bus.FUNCT3[1:0] != 2'b11);
    assign b_sgn    = in_div ? ~bus.FUNCT3[0] : ~bus.FUNCT3[1];
    assign a_neg    = a_sgn & bus.OPERAND_A[31];
    assign b_neg    = b_sgn & bus.OPERAND_B[31];
    assign mag_a    = fix32(bus.OPERAND_A, a_neg);
    assign mag_b    = fix32(bus.OPERAND_B, b_neg);
    assign div_zero = in_div && (bus.OPERAND_B == 32'd0);
    assign div_ovf  = in_div && !bus.FUNCT3[0] && (bus.OPERAND_A == 32'h8000_0000)
                      && (bus.OPERAND_B == 32'hFFFF_FFFF);

    logic        fast_hit;
    logic [31:0] fast_res;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [32:0] fast_a, fast_b;
    logic signed [65:0] fast_prod;
    logic               fast_unused;

    assign fast_a      = {a_sgn & bus.OPERAND_A[31], bus.OPERAND_A};
    assign fast_b      = {b_sgn & bus.OPERAND_B[31], bus.OPERAND_B};
    assign fast_prod   = 66'(fast_a) * 66'(fast_b);
    assign fast_unused = ^fast_prod[65:64];
    assign fast_hit    = div_zero || div_ovf || !in_div;
    assign fast_res    = div_zero ? (bus.FUNCT3[1] ? bus.OPERAND_A : 32'hFFFF_FFFF) :
                         div_ovf  ? (bus.FUNCT3[1] ? 32'd0 : 32'h8000_0000) :
                         (bus.FUNCT3[1:0] == 2'b00) ? fast_prod[31:0] : fast_prod[63:32];
`else
    assign fast_hit    = div_zero || div_ovf;
    assign fast_res    = div_zero ? (bus.FUNCT3[1] ? bus.OPERAND_A : 32'hFFFF_FFFF) :
                         (bus.FUNCT3[1] ? 32'd0 : 32'h8000_0000);
`endif

    // One iteration: work_q holds {product_hi, multiplier} or {remainder, dividend}
    logic [32:0] mul_sum, div_shift, div_diff;
    logic [63:0] step, prod;
    logic [31:0] final_res;

    assign mul_sum   = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign div_shift = {work_q[63:32], work_q[31]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign step      = funct3_q[2] ?
                       (div_diff[32] ? {div_shift[31:0], work_q[30:0], 1'b0}
                                     : {div_diff[31:0],  work_q[30:0], 1'b1})
                     : {mul_sum, work_q[31:1]};
    assign prod      = fix64(step, neg_q);
    assign final_res = funct3_q[2] ?
                       (funct3_q[1] ? fix32(step[63:32], neg_rem_q) : fix32(step[31:0], neg_q))
                     : ((funct3_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32]);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        funct3_d  = funct3_q;
        rd_d      = rd_q;
        opnd_d    = opnd_q;
        work_d    = work_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        rd_out_d  = rd_out_q;
        if (bus.FLUSH) begin
            state_d = IDLE;
            count_d = 5'd0;
        end else begin
            case (state_q)
                CALC: begin
                    work_d  = step;
                    count_d = count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        result_d = final_res;
                        rd_out_d = rd_q;
                        state_d  = FINISH;
                    end
                end
                default: begin
                    // IDLE and FINISH both accept a new op
                    state_d = IDLE;
                    if (bus.START) begin
                        funct3_d  = bus.FUNCT3;
                        rd_d      = bus.RD_IN;
                        count_d   = 5'd0;
                        neg_d     = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        opnd_d    = in_div ? mag_b : mag_a;
                        work_d    = {32'd0, in_div ? mag_a : mag_b};
                        if (fast_hit) begin
                            result_d = fast_res;
                            rd_out_d = bus.RD_IN;
                            state_d  = FINISH;
                        end else begin
                            state_d  = CALC;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            count_q  <= 5'd0;
            result_q <= 32'd0;
            rd_out_q <= 5'd0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    always_ff @(posedge CLK) begin
        funct3_q  <= funct3_d;
        rd_q      <= rd_d;
        opnd_q    <= opnd_d;
        work_q    <= work_d;
        neg_q     <= neg_d;
        neg_rem_q <= neg_rem_d;
    end

    assign bus.RESULT = result_q;
    assign bus.RD_OUT = rd_out_q;
    assign bus.DONE   = (state_q == FINISH);
    assign bus.BUSY   = (state_q == CALC) ||
                        ((state_q == IDLE) && bus.START && !bus.FLUSH);
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: expected results queued at issue, checked at DONE.
module tb_ex_muldiv_unit;
    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    ex_muldiv_unit_if bus();
    ex_muldiv_unit dut (.CLK(CLK), .RESET(RESET), .bus(bus));

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = longint'(a);
        ub = longint'(b);
        p  = 64'd0;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (!f3[2]) begin
`ifdef MULDIV_FAST_MUL_EN
            return 1;
`else
            return 33;
`endif
        end
        if (b == 32'd0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Present an op in cycle S with START high; optionally queue its expected result.
    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input bit push);
        exp_t e;
        @(posedge CLK); #1;
        bus.START     = 1'b1;
        bus.FUNCT3    = f3;
        bus.OPERAND_A = a;
        bus.OPERAND_B = b;
        bus.RD_IN     = rd;
        if (push) begin
            e.res = model(f3, a, b);
            e.rd  = rd;
            e.lat = exp_lat(f3, a, b);
            sb_q.push_back(e);
        end
    endtask

    // Drop START after cycle S and wait (bounded) for DONE; lat = -1 on timeout.
    task automatic wait_done(output int lat, output int busy_n);
        busy_n = 0;
        lat    = -1;
        @(negedge CLK);
        if (bus.BUSY === 1'b1) busy_n++;
        @(posedge CLK); #1;
        bus.START = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge CLK);
            if (bus.DONE === 1'b1) begin
                lat = k;
                break;
            end
            if (bus.BUSY === 1'b1) busy_n++;
        end
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        bus.START = 1'b0;
        bus.FLUSH = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        n_checks++; if (bus.RESULT !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h want 00000000", bus.RESULT); end
        n_checks++; if (bus.RD_OUT !== 5'd0)  begin n_fail++; $display("FAIL reset_rd: got %0d want 0", bus.RD_OUT); end
        n_checks++; if (bus.DONE !== 1'b0)    begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.DONE); end
        n_checks++; if (bus.BUSY !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
        @(posedge CLK); #1;
        RESET = 1'b0;
    endtask

    task automatic test_mul;
        int   lat, bn;
        exp_t e;
        start_op(3'b000, 32'd6, 32'd7, 5'd5, 1);
        wait_done(lat, bn);
        e = sb_q.pop_front();
        n_checks++; if (bus.RESULT !== e.res) begin n_fail++; $display("FAIL mul_result: got %h want %h", bus.RESULT, e.res); end
        n_checks++; if (bus.RD_OUT !== e.rd)  begin n_fail++; $display("FAIL mul_rd: got %0d want %0d", bus.RD_OUT, e.rd); end
        n_checks++; if (lat !== e.lat)        begin n_fail++; $display("FAIL mul_latency: got %0d want %0d", lat, e.lat); end
        n_checks++; if (bn !== e.lat)         begin n_fail++; $display("FAIL mul_busy_cycles: got %0d want %0d", bn, e.lat); end
        @(negedge CLK);
        n_checks++; if (bus.DONE !== 1'b0)    begin n_fail++; $display("FAIL mul_done_pulse: got %b want 0", bus.DONE); end
        n_checks++; if (bus.RESULT !== e.res) begin n_fail++; $display("FAIL mul_result_hold: got %h want %h", bus.RESULT, e.res); end
    endtask

    task automatic test_mulh;
        logic [2:0]  f3 [3] = '{3'b001, 3'b011, 3'b010};
        logic [31:0] av [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bv [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002};
        int   lat, bn;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            start_op(f3[i], av[i], bv[i], 5'(10 + i), 1);
            wait_done(lat, bn);
            e = sb_q.pop_front();
            n_checks++; if (bus.RESULT !== e.res) begin n_fail++; $display("FAIL mulh_result[%0d]: got %h want %h", i, bus.RESULT, e.res); end
            n_checks++; if (bus.RD_OUT !== e.rd)  begin n_fail++; $display("FAIL mulh_rd[%0d]: got %0d want %0d", i, bus.RD_OUT, e.rd); end
            n_checks++; if (lat !== e.lat)        begin n_fail++; $display("FAIL mulh_latency[%0d]: got %0d want %0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_div;
        logic [2:0]  f3 [6] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110};
        logic [31:0] av [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd1000, 32'h1234_5678};
        logic [31:0] bv [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FF00};
        int   lat, bn;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            start_op(f3[i], av[i], bv[i], 5'(20 + i), 1);
            wait_done(lat, bn);
            e = sb_q.pop_front();
            n_checks++; if (bus.RESULT !== e.res) begin n_fail++; $display("FAIL div_result[%0d]: got %h want %h", i, bus.RESULT, e.res); end
            n_checks++; if (bus.RD_OUT !== e.rd)  begin n_fail++; $display("FAIL div_rd[%0d]: got %0d want %0d", i, bus.RD_OUT, e.rd); end
            n_checks++; if (lat !== e.lat)        begin n_fail++; $display("FAIL div_latency[%0d]: got %0d want %0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_fast_path;
        logic [2:0]  f3 [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
        logic [31:0] av [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bv [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        int   lat, bn;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            start_op(f3[i], av[i], bv[i], 5'(28 + i), 1);
            wait_done(lat, bn);
            e = sb_q.pop_front();
            n_checks++; if (bus.RESULT !== e.res) begin n_fail++; $display("FAIL fast_result[%0d]: got %h want %h", i, bus.RESULT, e.res); end
            n_checks++; if (bus.RD_OUT !== e.rd)  begin n_fail++; $display("FAIL fast_rd[%0d]: got %0d want %0d", i, bus.RD_OUT, e.rd); end
            n_checks++; if (lat !== 1)            begin n_fail++; $display("FAIL fast_latency[%0d]: got %0d want 1", i, lat); end
            n_checks++; if (bn !== 1)             begin n_fail++; $display("FAIL fast_busy_cycles[%0d]: got %0d want 1", i, bn); end
        end
    endtask

    task automatic test_flush;
        int          lat, bn, dones;
        exp_t        e;
        logic [31:0] keep_res;
        logic [4:0]  keep_rd;
        start_op(3'b101, 32'd100, 32'd7, 5'd3, 1);
        wait_done(lat, bn);
        e = sb_q.pop_front();
        n_checks++; if (bus.RESULT !== e.res) begin n_fail++; $display("FAIL flush_setup: got %h want %h", bus.RESULT, e.res); end
        keep_res = e.res;
        keep_rd  = e.rd;

        start_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd9, 0);
        @(posedge CLK); #1;
        bus.START = 1'b0;
        repeat (9) @(posedge CLK);
        #1;
        bus.FLUSH = 1'b1;
        @(negedge CLK);
        n_checks++; if (bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL flush_busy_in_calc: got %b want 1", bus.BUSY); end
        @(posedge CLK); #1;
        bus.FLUSH = 1'b0;
        @(negedge CLK);
        n_checks++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL flush_busy_after: got %b want 0", bus.BUSY); end
        dones = 0;
        repeat (40) begin
            @(negedge CLK);
            if (bus.DONE === 1'b1) dones++;
        end
        n_checks++; if (dones !== 0)            begin n_fail++; $display("FAIL flush_no_done: got %0d pulses want 0", dones); end
        n_checks++; if (bus.RESULT !== keep_res) begin n_fail++; $display("FAIL flush_result_kept: got %h want %h", bus.RESULT, keep_res); end
        n_checks++; if (bus.RD_OUT !== keep_rd)  begin n_fail++; $display("FAIL flush_rd_kept: got %0d want %0d", bus.RD_OUT, keep_rd); end

        start_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd9, 0);
        @(posedge CLK); #1;
        bus.START = 1'b0;
        repeat (9) @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        n_checks++; if (bus.RESULT !== 32'd0) begin n_fail++; $display("FAIL midreset_result: got %h want 00000000", bus.RESULT); end
        n_checks++; if (bus.RD_OUT !== 5'd0)  begin n_fail++; $display("FAIL midreset_rd: got %0d want 0", bus.RD_OUT); end
        n_checks++; if (bus.BUSY !== 1'b0)    begin n_fail++; $display("FAIL midreset_busy: got %b want 0", bus.BUSY); end
        dones = 0;
        repeat (40) begin
            @(negedge CLK);
            if (bus.DONE === 1'b1) dones++;
        end
        n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d pulses want 0", dones); end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   dones, first, second;
        start_op(3'b101, 32'd100, 32'd7, 5'd1, 1);
        @(posedge CLK); #1;
        bus.FUNCT3    = 3'b111;
        bus.OPERAND_A = 32'd100;
        bus.OPERAND_B = 32'd7;
        bus.RD_IN     = 5'd2;
        e.res = model(3'b111, 32'd100, 32'd7);
        e.rd  = 5'd2;
        e.lat = 33;
        sb_q.push_back(e);
        dones  = 0;
        first  = -1;
        second = -1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge CLK);
            if (bus.DONE === 1'b1) begin
                dones++;
                if (first < 0 || second < 0) begin
                    e = sb_q.pop_front();
                    if (first < 0) first = k; else second = k;
                    n_checks++; if (bus.RESULT !== e.res) begin n_fail++; $display("FAIL b2b_result@%0d: got %h want %h", k, bus.RESULT, e.res); end
                    n_checks++; if (bus.RD_OUT !== e.rd)  begin n_fail++; $display("FAIL b2b_rd@%0d: got %0d want %0d", k, bus.RD_OUT, e.rd); end
                end
            end
            @(posedge CLK); #1;
            if (k + 1 == 34) begin
                bus.START = 1'b0;
            end else if (k + 1 >= 36 && k + 1 <= 60) begin
                bus.START     = ((k + 1) % 2) == 1;
                bus.FUNCT3    = 3'($urandom_range(0, 7));
                bus.OPERAND_A = $urandom;
                bus.OPERAND_B = $urandom;
                bus.RD_IN     = 5'($urandom_range(0, 31));
            end
        end
        bus.START = 1'b0;
        n_checks++; if (first !== 33)  begin n_fail++; $display("FAIL b2b_first_done: got %0d want 33", first); end
        n_checks++; if (second !== 66) begin n_fail++; $display("FAIL b2b_second_done: got %0d want 66", second); end
        n_checks++; if (dones !== 2)   begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", dones); end
    endtask

    initial begin
        RESET         = 1'b1;
        bus.START     = 1'b0;
        bus.FLUSH     = 1'b0;
        bus.FUNCT3    = 3'b000;
        bus.OPERAND_A = 32'd0;
        bus.OPERAND_B = 32'd0;
        bus.RD_IN     = 5'd0;
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_fast_path();
        test_flush();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Multi-cycle RV32M multiply/divide unit in the EX stage. It consumes the operands, funct3 and destination register delivered by the ID/EX pipeline register, and produces a 32-bit result for the EX/MEM register. While an operation is in flight it raises BUSY, which the pipeline registers take as their BUSY_WAIT stall input. Shift-add multiply and restoring divide take one iteration per cycle.

## Interface
- No parameters; datapath width fixed at 32.
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high.
- START  in  1  ID/EX holds a valid M-extension op; sampled on posedge.
- FUNCT3  in  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- OPERAND_A  in  32  rs1 value.
- OPERAND_B  in  32  rs2 value.
- RD_IN  in  5  destination register tag.
- FLUSH  in  1  abort the in-flight op (branch taken / exception).
- RESULT  out  32  registered result; holds its value until the next completion.
- RD_OUT  out  5  registered destination tag paired with RESULT.
- DONE  out  1  one-cycle pulse; RESULT/RD_OUT valid.
- BUSY  out  1  stall request to the pipeline registers.

## Operation
- States: IDLE, CALC, FINISH.
- IDLE, START=1: latch FUNCT3, RD_IN, operand magnitudes and result sign. Go to CALC with count=0, or take a fast path to FINISH.
- CALC, multiply: 32 shift-add steps on the unsigned magnitudes, giving a 64-bit product.
- CALC, divide: 32 restoring steps, giving quotient and remainder.
- Last step (count=31): apply sign fixup, register RESULT and RD_OUT, go to FINISH.
- MUL result: low word of the product.
- MULH, MULHSU, MULHU result: high word.
  - Signedness: MULH signed×signed; MULHSU signed rs1 × unsigned rs2; MULHU unsigned×unsigned.
- Signs: the quotient is negative iff the operand signs differ and the op is signed. The remainder takes the sign of the dividend.
- Fast path, divide by zero (B=0): quotient 0xFFFFFFFF, remainder equal to A (signed and unsigned). Goes straight to FINISH.
- Fast path, signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF): quotient 0x80000000, remainder 0. Goes straight to FINISH.
- FINISH: DONE=1 for that cycle only, then return to IDLE.
  - START=1 in FINISH is accepted: a back-to-back op loads on the same edge.
- START while in CALC is ignored.
- FLUSH=1 in any state: next edge goes to IDLE with no DONE. RESULT/RD_OUT are not updated.
  - FLUSH has priority over START in the same cycle.
- RESET: next edge goes to IDLE; count=0, RESULT=0, RD_OUT=0, DONE=0. Applies mid-operation too.

## Timing
- BUSY is combinational: 1 in CALC, and 1 in IDLE when START=1 and FLUSH=0. Otherwise 0 (including FINISH), so the pipeline advances on the edge ending FINISH and captures RESULT.
- Iterative op started in cycle S: CALC occupies S+1..S+32; DONE is high in S+33.
- Fast-path op started in cycle S: DONE is high in S+1; BUSY is high in S only.
- DONE never asserts two consecutive cycles except for back-to-back fast-path ops.
- Reset values: RESULT=0x00000000, RD_OUT=0, DONE=0, BUSY=0 (given START=0).

## Configuration
- MULDIV_FAST_MUL_EN defined: the multiply ops (FUNCT3[2]=0) use a combinational 33×33 signed multiplier. The result is registered on the START edge, DONE is high in S+1, and BUSY is high in S only.
- Not defined: the multiply ops use the 32-cycle iterative path above.
- Divide timing is identical either way.

## Test plan
- MUL 6×7, RD_IN=5 -> RESULT=0x0000002A, RD_OUT=5, DONE in S+33 (S+1 with MULDIV_FAST_MUL_EN); BUSY high S..S+32.
- MULH 0xFFFFFFFF×0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0x00000002 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM of the same -> 0; each with DONE in S+1.
- DIV started at S, FLUSH at S+10 -> BUSY low from S+11, no DONE, RESULT unchanged. Repeat with RESET at S+10 -> RESULT=0, RD_OUT=0.
- START held high through FINISH with new operands -> first DONE in S+33, second op loads on the same edge, second DONE in S+66; START pulses during CALC produce no extra DONE.
